// File: rtl/stage_mem_wb_if.sv
// MEM/WB stage bus: EX/MEM latch fields in, write-back fields out.
// The stage itself takes the slave view; the driving pipeline takes the master view.
interface stage_mem_wb_if;
    logic [31:0] inAlu;
    logic [31:0] inDataRt;
    logic [4:0]  inMuxRtRd;
    logic        inMemRead;
    logic        inMemWrite;
    logic        inRegWrite;
    logic [1:0]  inMemtoReg;
    logic [2:0]  inflagLoadWordDividerMEM;
    logic [1:0]  inflagStoreWordDividerMEM;
    logic [31:0] outMuxWb;
    logic [4:0]  outWriteReg;
    logic        outRegWrite;
    logic        outAddrError;
    logic [7:0]  outErrCount;

    modport master (
        output inAlu, inDataRt, inMuxRtRd, inMemRead, inMemWrite, inRegWrite, inMemtoReg,
               inflagLoadWordDividerMEM, inflagStoreWordDividerMEM,
        input  outMuxWb, outWriteReg, outRegWrite, outAddrError, outErrCount
    );

    modport slave (
        input  inAlu, inDataRt, inMuxRtRd, inMemRead, inMemWrite, inRegWrite, inMemtoReg,
               inflagLoadWordDividerMEM, inflagStoreWordDividerMEM,
        output outMuxWb, outWriteReg, outRegWrite, outAddrError, outErrCount
    );
endinterface

// File: rtl/stage_mem_wb.sv
// MEM/WB pipeline stage: 256x32 big-endian data memory with byte/half/word access,
// misalignment detection with a saturating error counter, and the MEM/WB latch.
module stage_mem_wb (
    input  logic          clk,
    input  logic          reset_n,
    stage_mem_wb_if.slave bus
);

    typedef enum logic [1:0] {SizeByte, SizeHalf, SizeWord} accessSize_e;

    logic [31:0] dataMem [256];

    logic [7:0]   index;
    logic [1:0]   offset;
    logic [4:0]   byteShift;
    accessSize_e  loadSize;
    accessSize_e  storeSize;
    logic         loadSigned;
    logic         loadMisaligned;
    logic         storeMisaligned;
    logic         addrError;
    logic [31:0]  readWord;
    logic [7:0]   readByte;
    logic [15:0]  readHalf;
    logic [31:0]  loadResult;
    logic [31:0]  writeMask;
    logic [31:0]  writeData;
    logic         memWriteEn;

    logic [31:0]  memWbAlu;
    logic [31:0]  memWbLoad;
    logic [4:0]   memWbRd;
    logic [1:0]   memWbMemtoReg;
    logic         memWbRegWrite;
    logic         memWbAddrError;
    logic [7:0]   errCount;

    always_comb begin
        index  = bus.inAlu[9:2];
        offset = bus.inAlu[1:0];
        // Big-endian: byte offset 0 lives in bits 31:24, so shift by (3 - offset) * 8.
        byteShift = {~offset, 3'b000};

        unique case (bus.inflagLoadWordDividerMEM)
            3'b001, 3'b010: loadSize = SizeByte;
            3'b011, 3'b100: loadSize = SizeHalf;
            default:        loadSize = SizeWord;
        endcase
        loadSigned = (bus.inflagLoadWordDividerMEM == 3'b001) ||
                     (bus.inflagLoadWordDividerMEM == 3'b011);

        unique case (bus.inflagStoreWordDividerMEM)
            2'b01:   storeSize = SizeByte;
            2'b10:   storeSize = SizeHalf;
            default: storeSize = SizeWord;
        endcase

        loadMisaligned  = (loadSize == SizeWord && offset != 2'b00) ||
                          (loadSize == SizeHalf && offset[0]);
        storeMisaligned = (storeSize == SizeWord && offset != 2'b00) ||
                          (storeSize == SizeHalf && offset[0]);
        addrError = (bus.inMemRead && loadMisaligned) || (bus.inMemWrite && storeMisaligned);
    end

    always_comb begin
        readWord = dataMem[index];
        readByte = 8'(readWord >> byteShift);
        readHalf = offset[1] ? readWord[15:0] : readWord[31:16];

        unique case (loadSize)
            SizeByte: loadResult = {{24{loadSigned & readByte[7]}}, readByte};
            SizeHalf: loadResult = {{16{loadSigned & readHalf[15]}}, readHalf};
            default:  loadResult = readWord;
        endcase
    end

    always_comb begin
        unique case (storeSize)
            SizeByte: begin
                writeMask = 32'h0000_00FF << byteShift;
                writeData = {4{bus.inDataRt[7:0]}};
            end
            SizeHalf: begin
                writeMask = offset[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
                writeData = {2{bus.inDataRt[15:0]}};
            end
            default: begin
                writeMask = 32'hFFFF_FFFF;
                writeData = bus.inDataRt;
            end
        endcase
        // Reset gates the write so no store lands while the pipeline is held in reset.
        memWriteEn = bus.inMemWrite && !addrError && reset_n;
    end

    // Memory contents survive reset; read-modify-write keeps unselected lanes.
    always_ff @(posedge clk) begin
        if (memWriteEn) begin
            dataMem[index] <= (readWord & ~writeMask) | (writeData & writeMask);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            memWbAlu       <= 32'd0;
            memWbLoad      <= 32'd0;
            memWbRd        <= 5'd0;
            memWbMemtoReg  <= 2'd0;
            memWbRegWrite  <= 1'b0;
            memWbAddrError <= 1'b0;
            errCount       <= 8'd0;
        end else begin
            memWbAlu       <= bus.inAlu;
            memWbLoad      <= loadResult;
            memWbRd        <= bus.inMuxRtRd;
            memWbMemtoReg  <= bus.inMemtoReg;
            memWbRegWrite  <= bus.inRegWrite && !addrError;
            memWbAddrError <= addrError;
            if (addrError && errCount != 8'hFF) begin
                errCount <= errCount + 8'd1;
            end
        end
    end

    always_comb begin
        bus.outMuxWb     = (memWbMemtoReg == 2'b01) ? memWbLoad : memWbAlu;
        bus.outWriteReg  = memWbRd;
        bus.outRegWrite  = memWbRegWrite;
        bus.outAddrError = memWbAddrError;
        bus.outErrCount  = errCount;
    end

endmodule

// File: doc/stage_mem_wb.md
STAGE_MEM_WB -- requirements
Module: stage_mem_wb

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port inAlu, input, 32 bits: ALU result from the EX/MEM latch, used as data address and as the non-memory result.
REQ-004 SHALL have port inDataRt, input, 32 bits: store data from the EX/MEM latch.
REQ-005 SHALL have port inMuxRtRd, input, 5 bits: destination register number.
REQ-006 SHALL have ports inMemRead, inMemWrite and inRegWrite, each input, 1 bit: control flags from EX/MEM.
REQ-007 SHALL have port inMemtoReg, input, 2 bits: write-back source select.
REQ-008 SHALL have port inflagLoadWordDividerMEM, input, 3 bits: load width; 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, other codes LW.
REQ-009 SHALL have port inflagStoreWordDividerMEM, input, 2 bits: store width; 00 SW, 01 SB, 10 SH, 11 SW.
REQ-010 SHALL have port outMuxWb, output, 32 bits: write-back data to the register file, also fed back to the EX forwarding muxes.
REQ-011 SHALL have port outWriteReg, output, 5 bits: write-back register number.
REQ-012 SHALL have port outRegWrite, output, 1 bit: register-file write enable.
REQ-013 SHALL have port outAddrError, output, 1 bit: registered misaligned-access flag.
REQ-014 SHALL have port outErrCount, output, 8 bits: saturating count of misaligned accesses.

Function
REQ-015 SHALL contain 256x32 data memory, indexed by inAlu[9:2], with asynchronous read and synchronous write; inAlu[31:10] ignored.
REQ-016 SHALL use big-endian lanes: byte offset 0 = bits 31:24, offset 3 = bits 7:0; halfword offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-017 SHALL flag a misaligned access when inMemRead or inMemWrite is 1 and any of the following holds: word with inAlu[1:0]!=0, or halfword with inAlu[0]=1.
REQ-018 SHALL write on a rising edge when inMemWrite=1 and the access is aligned, updating only the selected lanes with the low 8/16/32 bits of inDataRt; other lanes are preserved.
REQ-019 SHALL suppress the memory write and force the latched RegWrite to 0 on a misaligned access.
REQ-020 SHALL form the load result from the selected lane: LB/LH sign-extend, LBU/LHU zero-extend, LW uses the full word.
REQ-021 SHALL latch into the MEM/WB register on every rising edge: inAlu, the load result, inMuxRtRd, inMemtoReg, the gated RegWrite and the misaligned flag.
REQ-022 SHALL drive outMuxWb combinationally from the MEM/WB register: latched load result when latched MemtoReg=01, latched ALU value otherwise.
REQ-023 SHALL drive outWriteReg, outRegWrite and outAddrError directly from the MEM/WB register; latency from inputs to outputs is one clock.
REQ-024 SHALL increment outErrCount on each edge with a misaligned access and hold it at 255 (no wrap).
REQ-025 SHALL let a load in the cycle after a store to the same address observe the new data, because the write occurs before the asynchronous read.
REQ-026 SHALL return the pre-write contents for a read of the address being written in the same cycle as the store.
REQ-027 SHALL treat simultaneous inMemRead=1 and inMemWrite=1 as a store plus a load of old data.

Reset
REQ-028 SHALL asynchronously clear, while reset_n=0, all MEM/WB fields and outErrCount to 0, so that outMuxWb=0, outWriteReg=0, outRegWrite=0 and outAddrError=0.
REQ-029 SHALL NOT reset data memory contents.
REQ-030 SHALL block memory writes while reset_n=0.
REQ-031 SHALL discard an access in flight when reset is asserted mid-operation.
REQ-032 SHALL take effect on the first rising edge after reset_n deasserts.

Verification
REQ-033 SW 0x11223344 at 0x10, then LW 0x10, MemtoReg=01, rd=5 -> one cycle later outMuxWb=0x11223344, outWriteReg=5, outRegWrite=1.
REQ-034 After REQ-033, LB 0x13 -> 0x00000044; LB 0x10 after SB 0x80 at 0x10 -> 0xFFFFFF80; LBU 0x10 -> 0x00000080.
REQ-035 SH 0xBEEF at 0x12 over 0x11223344 -> LW 0x10 returns 0x1122BEEF; LH 0x12 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000BEEF.
REQ-036 SW at 0x11 with RegWrite=1 -> memory unchanged, outRegWrite=0, outAddrError=1, outErrCount=1; 300 misaligned accesses -> outErrCount=255.
REQ-037 MemtoReg=00, inAlu=0xDEADBEEF, rd=31 -> outMuxWb=0xDEADBEEF next cycle, no memory change.
REQ-038 reset_n pulsed low between edges -> all outputs 0 immediately; memory data previously written is still readable after release.
